// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues credit-limited word fetches and buffers responses for decode.
// Optional perf counters are enabled with `define IFU_PERF_CNT_EN.
module instr_fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [DATA_W-1:0] dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic [5:0]        dec_op,
  output logic [5:0]        dec_fcode,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [ADDR_W-1:0] tag_mem  [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, tag_rd_ptr, tag_wr_ptr;
  logic [CNT_W-1:0]  count, inflight, drop;
  logic [CNT_W-1:0]  inflight_nxt;
  logic              credit_ok, req_fire, push, pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue side: credits cover both buffered and outstanding words, so the FIFO can never overflow.
  assign credit_ok      = ({1'b0, count} + {1'b0, inflight}) < (CNT_W + 1)'(DEPTH);
  assign imem_req_valid = !reset && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign inflight_nxt   = inflight + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);

  // Response side: a redirect in the same cycle makes the arriving word stale as well.
  assign push = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign pop  = dec_valid && dec_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= ADDR_W'(RESET_PC);
      count      <= '0;
      inflight   <= '0;
      drop       <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      tag_rd_ptr <= '0;
      tag_wr_ptr <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (req_fire)
        tag_wr_ptr <= next_ptr(tag_wr_ptr);
      if (imem_rsp_valid)
        tag_rd_ptr <= next_ptr(tag_rd_ptr);
      if (redirect_valid) begin
        // Everything still outstanding after this edge belongs to the old path.
        pc     <= redirect_pc & ~ADDR_W'(3);
        drop   <= inflight_nxt;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (req_fire)
          pc <= pc + ADDR_W'(4);
        if (imem_rsp_valid && (drop != '0))
          drop <= drop - CNT_W'(1);
        if (push)
          wr_ptr <= next_ptr(wr_ptr);
        if (pop)
          rd_ptr <= next_ptr(rd_ptr);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      tag_mem[tag_wr_ptr] <= pc;
    if (push) begin
      data_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]   <= tag_mem[tag_rd_ptr];
    end
  end

  // Head presentation: outputs read zero whenever the FIFO is empty, including right after reset.
  assign dec_valid = (count != '0);
  assign dec_instr = dec_valid ? data_mem[rd_ptr] : '0;
  assign dec_pc    = dec_valid ? pc_mem[rd_ptr]   : '0;
  assign dec_op    = dec_instr[31:26];
  assign dec_fcode = dec_instr[5:0];

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (dec_ready && !dec_valid)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model with random latency and a queue-based stream model.
module tb_instr_fetch_unit;
  localparam int ADDR_W = 8, DATA_W = 32, DEPTH = 2, RESET_PC = 0;

  logic clk = 1'b0;
  logic reset, imem_req_valid, imem_req_ready, imem_rsp_valid, dec_valid, dec_ready, redirect_valid;
  logic [ADDR_W-1:0] imem_req_addr, dec_pc, redirect_pc;
  logic [DATA_W-1:0] imem_rsp_data, dec_instr;
  logic [5:0] dec_op, dec_fcode;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
  logic [31:0] m_fetch, m_stall;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .dec_op(dec_op), .dec_fcode(dec_fcode),
`ifdef IFU_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [31:0] mem [64];

  // Stimulus knobs
  int rdy_pct, dec_pct, redir_pct, lat_min, lat_max, reset_pm;
  bit knob_reset, force_redir;
  logic [7:0] force_pc;
  int cyc = 0;

  // Memory environment: addresses accepted by the DUT and the cycle each may respond in
  logic [7:0] mq_addr[$];
  int         mq_rdy[$];

  // Reference model: next fetch pc, words visible to decode, outstanding fetches with stale marks
  logic [7:0] m_pc;
  logic [7:0] m_buf[$];
  logic [7:0] m_fl_addr[$];
  bit         m_fl_stale[$];
  bit         after_reset = 0;

  // Per-phase observation logs
  logic [7:0] acc_addr_log[$], pop_pc_log[$], req_addr_log[$];
  logic [5:0] pop_op_log[$], pop_fcode_log[$];
  logic [31:0] dinstr_log[$];
  int acc_cyc_log[$], dv_cyc_log[$];
  bit dv_log[$], rv_log[$];

  task automatic clear_logs();
    acc_addr_log.delete(); pop_pc_log.delete(); req_addr_log.delete();
    pop_op_log.delete(); pop_fcode_log.delete(); dinstr_log.delete();
    acc_cyc_log.delete(); dv_cyc_log.delete(); dv_log.delete(); rv_log.delete();
  endtask

  always @(negedge clk) begin : cmp
    bit exp_rv;
    logic [7:0] hpc, a;
    bit st;
    int r;
    if (reset) begin
      chk("req_valid_in_reset", imem_req_valid, 1'b0);
      m_pc = RESET_PC;
      m_buf.delete(); m_fl_addr.delete(); m_fl_stale.delete();
      mq_addr.delete(); mq_rdy.delete();
      after_reset = 1;
`ifdef IFU_PERF_CNT_EN
      m_fetch = 0; m_stall = 0;
`endif
    end else begin
      exp_rv = !redirect_valid && ((m_buf.size() + m_fl_addr.size()) < DEPTH);
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
      chk("dec_valid", dec_valid, m_buf.size() != 0);
      if (after_reset) begin
        chk("instr_after_reset", dec_instr, 0);
        chk("pc_after_reset", dec_pc, 0);
        chk("op_fcode_after_reset", {dec_op, dec_fcode}, 0);
        after_reset = 0;
      end
      if (m_buf.size() != 0) begin
        hpc = m_buf[0];
        chk("dec_pc", dec_pc, hpc);
        chk("dec_instr", dec_instr, mem[hpc[7:2]]);
        chk("dec_op", dec_op, mem[hpc[7:2]] >> 26);
        chk("dec_fcode", dec_fcode, mem[hpc[7:2]] & 32'h3F);
      end
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_cnt, m_fetch);
      chk("perf_stall", perf_stall_cnt, m_stall);
      if (m_buf.size() != 0 && dec_ready) m_fetch++;
      if (m_buf.size() == 0 && dec_ready) m_stall++;
`endif
      // logs of what the DUT actually did
      req_addr_log.push_back(imem_req_addr);
      rv_log.push_back(imem_req_valid);
      dv_log.push_back(dec_valid);
      if (dec_valid) begin
        dv_cyc_log.push_back(cyc);
        dinstr_log.push_back(dec_instr);
      end
      if (dec_valid && dec_ready) begin
        pop_pc_log.push_back(dec_pc);
        pop_op_log.push_back(dec_op);
        pop_fcode_log.push_back(dec_fcode);
      end
      if (imem_req_valid && imem_req_ready) begin
        acc_addr_log.push_back(imem_req_addr);
        acc_cyc_log.push_back(cyc);
        r = cyc + 1 + $urandom_range(lat_max, lat_min);
        if (mq_rdy.size() != 0 && r < mq_rdy[$]) r = mq_rdy[$];
        mq_addr.push_back(imem_req_addr);
        mq_rdy.push_back(r);
      end
      // advance model across the coming edge
      if (m_buf.size() != 0 && dec_ready) void'(m_buf.pop_front());
      if (imem_rsp_valid) begin
        if (m_fl_addr.size() == 0) begin
          chk("rsp_with_nothing_outstanding", 1'b1, 1'b0);
        end else begin
          a = m_fl_addr.pop_front();
          st = m_fl_stale.pop_front();
          if (!st && !redirect_valid) m_buf.push_back(a);
        end
      end
      if (exp_rv && imem_req_ready) begin
        m_fl_addr.push_back(m_pc);
        m_fl_stale.push_back(1'b0);
        m_pc = m_pc + 8'd4;
      end
      if (redirect_valid) begin
        m_buf.delete();
        foreach (m_fl_stale[i]) m_fl_stale[i] = 1'b1;
        m_pc = redirect_pc & 8'hFC;
      end
    end
    cyc++;
  end

  task automatic drive();
    reset = knob_reset || ($urandom_range(999, 0) < reset_pm);
    imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
    dec_ready = ($urandom_range(99, 0) < dec_pct);
    redirect_valid = !reset && (force_redir || ($urandom_range(99, 0) < redir_pct));
    redirect_pc = force_redir ? force_pc : 8'($urandom);
    imem_rsp_valid = 1'b0;
    imem_rsp_data = $urandom;
    if (!reset && mq_rdy.size() != 0 && mq_rdy[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem[mq_addr[0][7:2]];
      void'(mq_addr.pop_front());
      void'(mq_rdy.pop_front());
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic do_reset();
    knob_reset = 1; force_redir = 0;
    run(2);
    clear_logs();
    knob_reset = 0;
  endtask

  task automatic knobs(input int rp, input int dp, input int xp, input int lmin, input int lmax);
    rdy_pct = rp; dec_pct = dp; redir_pct = xp; lat_min = lmin; lat_max = lmax;
  endtask

  int diffs;
  int snap;

  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    mem[2] = 32'h014B4820;
    reset_pm = 0; force_pc = 0; force_redir = 0; knob_reset = 1;
    knobs(100, 100, 0, 0, 0);
    drive();

    // Streaming with a 1-cycle memory
    do_reset();
    run(12);
    chk("a_acc_count", acc_addr_log.size() >= 3, 1'b1);
    if (acc_addr_log.size() >= 3) begin
      chk("a_acc0", acc_addr_log[0], 8'h00);
      chk("a_acc1", acc_addr_log[1], 8'h04);
      chk("a_acc2", acc_addr_log[2], 8'h08);
    end
    chk("a_pop_count", pop_pc_log.size() >= 3, 1'b1);
    if (pop_pc_log.size() >= 3) begin
      chk("a_pop0", pop_pc_log[0], 8'h00);
      chk("a_pop1", pop_pc_log[1], 8'h04);
      chk("a_pop2", pop_pc_log[2], 8'h08);
      chk("a_op_at_08", pop_op_log[2], 6'b000000);
      chk("a_fcode_at_08", pop_fcode_log[2], 6'b100000);
    end
    if (dv_cyc_log.size() != 0 && acc_cyc_log.size() != 0)
      chk("a_first_dv_latency", dv_cyc_log[0] - acc_cyc_log[0], 2);
    else
      chk("a_first_dv_seen", 1'b0, 1'b1);

    // Decode backpressure fills the credits
    knobs(100, 0, 0, 0, 0);
    do_reset();
    run(10);
    chk("b_acc_count", acc_addr_log.size(), 2);
    if (acc_addr_log.size() >= 2) begin
      chk("b_acc0", acc_addr_log[0], 8'h00);
      chk("b_acc1", acc_addr_log[1], 8'h04);
    end
    chk("b_req_idle", rv_log[$], 1'b0);
    diffs = 0;
    foreach (dinstr_log[i]) if (dinstr_log[i] !== mem[0]) diffs++;
    chk("b_instr_stable", diffs, 0);
    chk("b_instr_held_count", dinstr_log.size() >= 6, 1'b1);
    knobs(100, 100, 0, 0, 0);
    run(6);
    if (acc_addr_log.size() >= 3) chk("b_resume", acc_addr_log[2], 8'h08);
    else chk("b_resume_seen", 1'b0, 1'b1);

    // Redirect with two fetches outstanding, misaligned target
    knobs(100, 100, 0, 2, 2);
    do_reset();
    force_redir = 1; force_pc = 8'h10; run(1);
    force_redir = 0; run(2);
    force_redir = 1; force_pc = 8'h42; run(1);
    force_redir = 0; run(12);
    chk("c_addr_after_redirect", req_addr_log[4], 8'h40);
    chk("c_acc_count", acc_addr_log.size() >= 3, 1'b1);
    if (acc_addr_log.size() >= 3) begin
      chk("c_acc0", acc_addr_log[0], 8'h10);
      chk("c_acc1", acc_addr_log[1], 8'h14);
      chk("c_acc2", acc_addr_log[2], 8'h40);
    end
    if (pop_pc_log.size() != 0) chk("c_first_pop", pop_pc_log[0], 8'h40);
    else chk("c_first_pop_seen", 1'b0, 1'b1);

    // PC wrap
    knobs(100, 100, 0, 0, 0);
    do_reset();
    force_redir = 1; force_pc = 8'hFC; run(1);
    force_redir = 0; run(8);
    if (acc_addr_log.size() >= 2) begin
      chk("d_acc_fc", acc_addr_log[0], 8'hFC);
      chk("d_acc_wrap", acc_addr_log[1], 8'h00);
    end else chk("d_acc_seen", 1'b0, 1'b1);
    if (pop_pc_log.size() != 0) chk("d_pop_fc", pop_pc_log[0], 8'hFC);
    else chk("d_pop_seen", 1'b0, 1'b1);

    // Reset while two fetches are outstanding
    knobs(100, 100, 0, 2, 2);
    do_reset();
    run(3);
    snap = acc_addr_log.size();
    chk("e_two_in_flight", snap, 2);
    knob_reset = 1; run(1);
    clear_logs();
    knob_reset = 0; run(6);
    chk("e_dv_after_reset", dv_log[0], 1'b0);
    if (acc_addr_log.size() != 0) chk("e_acc_reset_pc", acc_addr_log[0], RESET_PC);
    else chk("e_acc_seen", 1'b0, 1'b1);

    // Random traffic
    knobs(70, 60, 5, 0, 3);
    do_reset();
    reset_pm = 4;
    run(4000);
    reset_pm = 0;
    knobs(100, 100, 0, 0, 0);
    run(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Produces the instruction stream consumed by the opcode/function decode stage.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words in a small FIFO and presents instr/pc/op/fcode to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute and flushes all stale words.

Parameters:
ADDR_W, 8, PC and memory address width; PC wraps modulo 2^ADDR_W.
DATA_W, 32, instruction word width; op = bits [31:26], fcode = bits [5:0].
DEPTH, 2, FIFO entries, also the maximum words in flight; legal range 2..8.
RESET_PC, 0, PC value loaded on reset; must be a multiple of 4.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  fetch address, equal to the current PC
imem_rsp_valid  in  1  response word valid; in order; no backpressure
imem_rsp_data  in  DATA_W  response instruction word
dec_valid  out  1  FIFO head valid
dec_ready  in  1  decode consumes the head
dec_instr  out  DATA_W  head instruction word
dec_pc  out  ADDR_W  address the head word was fetched from
dec_op  out  6  dec_instr[31:26]
dec_fcode  out  6  dec_instr[5:0]
redirect_valid  in  1  branch/jump taken
redirect_pc  in  ADDR_W  new fetch target

Behaviour:
- Reset (synchronous, active-high, wins over all inputs):
  - pc = RESET_PC.
  - FIFO empty; inflight = 0; drop = 0.
  - imem_req_valid = 0, dec_valid = 0.
  - dec_instr, dec_pc, dec_op and dec_fcode = 0.
  - A reset mid-operation discards all in-flight responses; the memory is reset with this block.
- Credits: imem_req_valid = !reset && !redirect_valid && (count + inflight < DEPTH).
  - A request is accepted when imem_req_valid && imem_req_ready.
  - On acceptance: pc <= pc + 4 (wraps modulo 2^ADDR_W) and inflight increments.
  - Each response decrements inflight.
  - Minimum response latency is 1 cycle after acceptance.
- Responses:
  - When drop == 0, the response is written to the FIFO tail with its tag pc.
  - Tag pcs come from a parallel tag FIFO of issued addresses.
  - When drop > 0, the response is discarded and drop decrements.
  - The FIFO never overflows because of the credit rule.
- Decode handshake:
  - dec_valid = (count != 0); dec_* are driven from the head entry.
  - The head is popped on dec_valid && dec_ready.
  - Outputs remain stable while dec_valid && !dec_ready.
  - A push and a pop in the same cycle leave count unchanged.
  - A write into an empty FIFO becomes visible on the next cycle, giving a memory-response-to-dec_valid latency of 1 cycle.
- Redirect (redirect_valid = 1):
  - The FIFO is flushed and pc <= redirect_pc.
  - drop <= inflight + (request accepted this cycle ? 1 : 0) - (response this cycle ? 1 : 0).
  - No request is issued in the redirect cycle; issue resumes the following cycle at redirect_pc.
  - A dec handshake in the same cycle counts as consumed. The redirect still flushes the rest of the FIFO.
  - Redirects on consecutive cycles are legal; the last one wins.
  - drop accumulates correctly across back-to-back redirects.
  - A response that arrives while drop > 0 and a new redirect occurs together: the response is dropped and the redirect recomputes drop per the formula above.
  - A misaligned redirect_pc (low 2 bits != 0) is forced to a 4-byte boundary by clearing bits [1:0].
- Pointers are log2(DEPTH)-bit with wrap-around; count is a separate register (0..DEPTH).

Optional Feature:
IFU_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt (32 bits) and perf_stall_cnt (32 bits), both reset to 0.
  - perf_fetch_cnt increments on every dec handshake.
  - perf_stall_cnt increments on every cycle with dec_ready && !dec_valid.
  - Both wrap at 2^32.
  - Neither counter changes on redirect.
- Undefined: the ports and the logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then imem_req_ready = 1, 1-cycle memory, dec_ready = 1 → request addrs 0x00, 0x04, 0x08…; dec_pc follows in the same order; first dec_valid 2 cycles after the first acceptance.
- dec_ready = 0 with the memory always ready → exactly DEPTH = 2 requests accepted (0x00, 0x04), then imem_req_valid = 0; dec_instr is held stable; dec_ready = 1 resumes issue at 0x08.
- Two requests in flight (0x10, 0x14), redirect_valid with redirect_pc = 0x40 → both responses dropped; the next request addr is 0x40 one cycle after the redirect; the first dec_pc is 0x40.
- pc = 0xFC accepted → the next request addr is 0x00 (wrap); dec_pc of that word is 0xFC.
- Response word 0x014B4820 → dec_op = 6'b000000, dec_fcode = 6'b100000.
- Reset asserted while 2 responses are in flight → dec_valid = 0 next cycle; the next request addr is RESET_PC. With IFU_PERF_CNT_EN: 5 consumed instructions and 3 starved cycles give perf_fetch_cnt = 5 and perf_stall_cnt = 3.
